// File: rtl/wt_cache_pkg.sv
// Shared write-through cache definitions: L1.5 message types, chunk size codes,
// store-split FSM states and the lane replication helper.
package wt_cache_pkg;

  typedef enum logic [4:0] {
    L15_LOAD_RQ   = 5'b00000,
    L15_STORE_RQ  = 5'b00001,
    L15_ATOMIC_RQ = 5'b00110,
    L15_IMISS_RQ  = 5'b10000
  } l15_reqtypes_t;

  typedef enum logic [3:0] {
    L15_LOAD_RET = 4'b0000,
    L15_ST_ACK   = 4'b0100,
    L15_INT_RET  = 4'b0111,
    L15_EVICT_REQ = 4'b0011
  } l15_rtrntypes_t;

  localparam logic [2:0] L15_SIZE_BYTE  = 3'b000;
  localparam logic [2:0] L15_SIZE_HWORD = 3'b001;
  localparam logic [2:0] L15_SIZE_WORD  = 3'b010;
  localparam logic [2:0] L15_SIZE_DWORD = 3'b011;

  typedef enum logic {
    SPLIT_IDLE,
    SPLIT_SEND
  } wt_st_split_state_t;

  // Chunk sits at bit 0 of data; callers narrower than 64 bits truncate the result.
  function automatic logic [63:0] repData(input logic [63:0] data, input logic [2:0] size);
    logic [63:0] rep;
    case (size)
      L15_SIZE_BYTE:  rep = {8{data[7:0]}};
      L15_SIZE_HWORD: rep = {4{data[15:0]}};
      L15_SIZE_WORD:  rep = {2{data[31:0]}};
      default:        rep = data;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/wt_store_chunk_sel.sv
// Picks the next L1.5-legal chunk from the remaining byte enables: the largest
// naturally aligned, fully enabled span starting at the lowest enabled byte.
module wt_store_chunk_sel #(
  parameter int BE_W = 8
) (
  input  logic [BE_W-1:0]         rem_be,
  output logic [$clog2(BE_W)-1:0] offset,
  output logic [2:0]              size,
  output logic [BE_W-1:0]         chunk_be
);
  localparam int OFF_W = $clog2(BE_W);

  logic            found;
  logic [BE_W-1:0] cand;
  int              off_int;
  int              span;

  always_comb begin
    offset   = '0;
    found    = 1'b0;
    off_int  = 0;
    span     = 1;
    cand     = '0;
    size     = 3'd0;
    chunk_be = '0;
    for (int i = 0; i < BE_W; i++) begin
      if (!found && rem_be[i]) begin
        offset  = OFF_W'(i);
        off_int = i;
        found   = 1'b1;
      end
    end
    // Legality shrinks monotonically with span, so the last passing span is the largest.
    for (int s = 0; s <= OFF_W; s++) begin
      span = 1 << s;
      for (int b = 0; b < BE_W; b++) begin
        cand[b] = (b >= off_int) && (b < off_int + span);
      end
      if (found && (off_int % span == 0) && ((rem_be & cand) == cand)) begin
        size     = 3'(s);
        chunk_be = cand;
      end
    end
  end

endmodule

// File: rtl/wt_l15_store_splitter.sv
// Splits one byte-enabled store into aligned L1.5 store chunks, each tagged with
// a transaction ID from a pool that ack returns free again.
module wt_l15_store_splitter
  import wt_cache_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int TID_W  = 3,
  parameter int ADDR_W = 40
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   st_val_i,
  output logic                   st_rdy_o,
  input  logic [ADDR_W-1:0]      st_addr_i,
  input  logic [DATA_W-1:0]      st_data_i,
  input  logic [DATA_W/8-1:0]    st_be_i,
  input  logic                   st_nc_i,
  output logic                   l15_val_o,
  input  logic                   l15_header_ack_i,
  output logic [ADDR_W-1:0]      l15_addr_o,
  output logic [DATA_W-1:0]      l15_data_o,
  output logic [2:0]             l15_size_o,
  output logic [TID_W-1:0]       l15_tid_o,
  output logic                   l15_nc_o,
  input  logic                   ack_val_i,
  input  logic [TID_W-1:0]       ack_tid_i,
  output logic                   idle_o,
  output logic [TID_W:0]         outst_o,
  output logic                   err_o
);
  localparam int BE_W   = DATA_W / 8;
  localparam int OFF_W  = $clog2(BE_W);
  localparam int NUM_TX = 2 ** TID_W;

  wt_st_split_state_t state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic [BE_W-1:0]    rem_be_q;
  logic               nc_q;
  logic [NUM_TX-1:0]  bitmap_q, bitmap_d;
  logic               err_q;

  logic [OFF_W-1:0]   chunk_off;
  logic [2:0]         chunk_size;
  logic [BE_W-1:0]    chunk_be;
  logic               free_found;
  logic [TID_W-1:0]   free_tid;
  logic               accept, fire, ack_hit;
  logic [TID_W:0]     count;
  logic               addr_lsb_unused;

  wt_store_chunk_sel #(.BE_W(BE_W)) u_chunk_sel (
    .rem_be   (rem_be_q),
    .offset   (chunk_off),
    .size     (chunk_size),
    .chunk_be (chunk_be)
  );

  assign addr_lsb_unused = ^st_addr_i[OFF_W-1:0];

  always_comb begin
    free_found = 1'b0;
    free_tid   = '0;
    for (int i = NUM_TX - 1; i >= 0; i--) begin
      if (!bitmap_q[i]) begin
        free_found = 1'b1;
        free_tid   = TID_W'(i);
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_TX; i++) begin
      count = count + {{TID_W{1'b0}}, bitmap_q[i]};
    end
  end

  assign st_rdy_o   = (state_q == SPLIT_IDLE);
  assign accept     = st_val_i & st_rdy_o;
  assign l15_val_o  = (state_q == SPLIT_SEND) & free_found;
  assign fire       = l15_val_o & l15_header_ack_i;
  assign l15_addr_o = addr_q | ADDR_W'(chunk_off);
  assign l15_size_o = chunk_size;
  assign l15_tid_o  = free_tid;
  assign l15_nc_o   = nc_q;
  assign l15_data_o = DATA_W'(repData(64'(data_q >> {chunk_off, 3'b000}), chunk_size));
  assign ack_hit    = ack_val_i & bitmap_q[ack_tid_i];
  assign idle_o     = st_rdy_o & ~|bitmap_q;
  assign outst_o    = count;
  assign err_o      = err_q;

  // Allocation looks at the pre-edge bitmap, so a TID freed this cycle is only reusable next cycle.
  always_comb begin
    bitmap_d = bitmap_q;
    if (ack_hit) bitmap_d[ack_tid_i] = 1'b0;
    if (fire)    bitmap_d[free_tid]  = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SPLIT_IDLE: if (accept && st_be_i != '0) state_d = SPLIT_SEND;
      SPLIT_SEND: if (fire && (rem_be_q & ~chunk_be) == '0) state_d = SPLIT_IDLE;
      default:    state_d = SPLIT_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= SPLIT_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      data_q   <= '0;
      rem_be_q <= '0;
      nc_q     <= 1'b0;
      bitmap_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= {st_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        data_q   <= st_data_i;
        rem_be_q <= st_be_i;
        nc_q     <= st_nc_i;
      end else if (fire) begin
        rem_be_q <= rem_be_q & ~chunk_be;
      end
      bitmap_q <= bitmap_d;
      if (ack_val_i && !bitmap_q[ack_tid_i]) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wt_l15_store_splitter.sv
// Randomised and directed bench for the L1.5 store splitter, checked against a
// chunk-list / TID-pool reference model kept in the bench.
module tb_wt_l15_store_splitter;

  typedef struct {
    logic [39:0] addr;
    logic [63:0] data;
    logic [2:0]  size;
    logic        nc;
  } chunk_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_val, st_rdy, st_nc;
  logic [39:0] st_addr;
  logic [63:0] st_data;
  logic [7:0]  st_be;
  logic        l15_val, hdr_ack, l15_nc;
  logic [39:0] l15_addr;
  logic [63:0] l15_data;
  logic [2:0]  l15_size, l15_tid;
  logic        ack_val;
  logic [2:0]  ack_tid;
  logic        idle, err;
  logic [3:0]  outst;

  logic        st_val32, st_rdy32, l15_val32, hdr_ack32, l15_nc32, ack_val32, idle32, err32;
  logic [39:0] st_addr32, l15_addr32;
  logic [31:0] st_data32, l15_data32;
  logic [3:0]  st_be32, outst32;
  logic [2:0]  l15_size32, l15_tid32, ack_tid32;

  int     vectors = 0;
  int     miscompares = 0;
  bit [7:0] m_bm;
  bit     m_err;
  chunk_t exp_q[$];

  always #5 clk = ~clk;

  wt_l15_store_splitter #(.DATA_W(64), .TID_W(3), .ADDR_W(40)) u_dut (
    .clk_i(clk), .rst_i(rst), .st_val_i(st_val), .st_rdy_o(st_rdy), .st_addr_i(st_addr),
    .st_data_i(st_data), .st_be_i(st_be), .st_nc_i(st_nc), .l15_val_o(l15_val),
    .l15_header_ack_i(hdr_ack), .l15_addr_o(l15_addr), .l15_data_o(l15_data),
    .l15_size_o(l15_size), .l15_tid_o(l15_tid), .l15_nc_o(l15_nc), .ack_val_i(ack_val),
    .ack_tid_i(ack_tid), .idle_o(idle), .outst_o(outst), .err_o(err)
  );

  wt_l15_store_splitter #(.DATA_W(32), .TID_W(3), .ADDR_W(40)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .st_val_i(st_val32), .st_rdy_o(st_rdy32), .st_addr_i(st_addr32),
    .st_data_i(st_data32), .st_be_i(st_be32), .st_nc_i(1'b0), .l15_val_o(l15_val32),
    .l15_header_ack_i(hdr_ack32), .l15_addr_o(l15_addr32), .l15_data_o(l15_data32),
    .l15_size_o(l15_size32), .l15_tid_o(l15_tid32), .l15_nc_o(l15_nc32), .ack_val_i(ack_val32),
    .ack_tid_i(ack_tid32), .idle_o(idle32), .outst_o(outst32), .err_o(err32)
  );

  // Greedy split: from the lowest enabled byte take the widest aligned, fully enabled span.
  function automatic void build_chunks(input logic [39:0] a, input logic [63:0] d,
                                       input logic [7:0] be, input logic nc);
    logic [7:0]  rem;
    logic [7:0]  span_mask;
    logic [63:0] lane, field;
    chunk_t      c;
    int          o, n;
    rem = be;
    while (rem != 8'h00) begin
      o = 0;
      while (!rem[o]) o++;
      n = 8;
      while (n > 1) begin
        span_mask = 8'((1 << n) - 1);
        if ((o % n == 0) && (((rem >> o) & span_mask) == span_mask)) break;
        n = n / 2;
      end
      span_mask = 8'((1 << n) - 1);
      lane  = d >> (o * 8);
      field = (n == 8) ? lane : (lane & ((64'd1 << (n * 8)) - 64'd1));
      c.data = '0;
      for (int k = 0; k < 8 / n; k++) c.data = c.data | (field << (k * n * 8));
      c.addr = {a[39:3], 3'b000} + 40'(o);
      c.size = (n == 1) ? 3'd0 : (n == 2) ? 3'd1 : (n == 4) ? 3'd2 : 3'd3;
      c.nc   = nc;
      exp_q.push_back(c);
      rem = rem & ~(span_mask << o);
    end
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < 8; i++) if (!m_bm[i]) return i;
    return -1;
  endfunction

  task automatic accept(input logic [39:0] a, input logic [63:0] d, input logic [7:0] be,
                        input logic nc);
    st_val = 1'b1; st_addr = a; st_data = d; st_be = be; st_nc = nc;
    @(posedge clk); #1;
    st_val = 1'b0;
    build_chunks(a, d, be, nc);
  endtask

  task automatic step(input bit hdr, input bit av, input logic [2:0] at);
    int t;
    t = lowest_free();
    hdr_ack = hdr; ack_val = av; ack_tid = at;
    @(posedge clk); #1;
    hdr_ack = 1'b0; ack_val = 1'b0;
    if (av) begin
      if (m_bm[at]) m_bm[at] = 1'b0;
      else m_err = 1'b1;
    end
    if (hdr && t >= 0 && exp_q.size() > 0) begin
      m_bm[t] = 1'b1;
      exp_q.delete(0);
    end
  endtask

  task automatic step32(input bit hdr, input bit av, input logic [2:0] at);
    hdr_ack32 = hdr; ack_val32 = av; ack_tid32 = at;
    @(posedge clk); #1;
    hdr_ack32 = 1'b0; ack_val32 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_bm = '0; m_err = 1'b0; exp_q.delete();
    vectors++; if (st_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_st_rdy got=%b exp=1", st_rdy); end
    vectors++; if (l15_val !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_l15_val got=%b exp=0", l15_val); end
    vectors++; if (idle !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_idle got=%b exp=1", idle); end
    vectors++; if (outst !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_outst got=%0d exp=0", outst); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err got=%b exp=0", err); end
    vectors++; if (idle32 !== 1'b1 || st_rdy32 !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_dut32 idle=%b rdy=%b exp=1/1", idle32, st_rdy32); end
  endtask

  task automatic test_full_dword();
    logic [63:0] d;
    d = {$urandom, $urandom};
    accept(40'h1000, d, 8'hFF, 1'b0);
    vectors++; if (l15_val !== 1'b1) begin miscompares++; $display("[TB] FAIL dword_val got=%b exp=1", l15_val); end
    vectors++; if (l15_addr !== 40'h1000) begin miscompares++; $display("[TB] FAIL dword_addr got=%h exp=%h", l15_addr, 40'h1000); end
    vectors++; if (l15_size !== 3'b011) begin miscompares++; $display("[TB] FAIL dword_size got=%b exp=011", l15_size); end
    vectors++; if (l15_tid !== 3'd0) begin miscompares++; $display("[TB] FAIL dword_tid got=%0d exp=0", l15_tid); end
    vectors++; if (l15_data !== d) begin miscompares++; $display("[TB] FAIL dword_data got=%h exp=%h", l15_data, d); end
    step(1'b1, 1'b0, 3'd0);
    vectors++; if (st_rdy !== 1'b1 || outst !== 4'd1 || idle !== 1'b0) begin miscompares++; $display("[TB] FAIL dword_after rdy=%b outst=%0d idle=%b exp=1/1/0", st_rdy, outst, idle); end
    step(1'b0, 1'b1, 3'd0);
    vectors++; if (outst !== 4'd0 || idle !== 1'b1) begin miscompares++; $display("[TB] FAIL dword_acked outst=%0d idle=%b exp=0/1", outst, idle); end
  endtask

  task automatic test_split();
    logic [39:0] ea [4];
    logic [2:0]  es [4];
    logic [63:0] d;
    ea = '{40'h2001, 40'h2002, 40'h2004, 40'h2006};
    es = '{3'b000, 3'b001, 3'b001, 3'b000};
    d = {$urandom, $urandom};
    accept(40'h2000, d, 8'b0111_1110, 1'b1);
    for (int i = 0; i < 4; i++) begin
      vectors++; if (l15_val !== 1'b1 || l15_tid !== 3'(i)) begin miscompares++; $display("[TB] FAIL split_val_tid[%0d] val=%b tid=%0d exp=1/%0d", i, l15_val, l15_tid, i); end
      vectors++; if (l15_addr !== ea[i] || l15_size !== es[i]) begin miscompares++; $display("[TB] FAIL split_addr_size[%0d] got=%h/%b exp=%h/%b", i, l15_addr, l15_size, ea[i], es[i]); end
      vectors++; if (l15_data !== exp_q[0].data || l15_nc !== 1'b1) begin miscompares++; $display("[TB] FAIL split_data[%0d] got=%h nc=%b exp=%h nc=1", i, l15_data, l15_nc, exp_q[0].data); end
      vectors++; if (st_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL split_busy[%0d] st_rdy got=%b exp=0", i, st_rdy); end
      step(1'b1, 1'b0, 3'd0);
    end
    vectors++; if (st_rdy !== 1'b1 || l15_val !== 1'b0 || outst !== 4'd4) begin miscompares++; $display("[TB] FAIL split_done rdy=%b val=%b outst=%0d exp=1/0/4", st_rdy, l15_val, outst); end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'(i));
    vectors++; if (idle !== 1'b1 || outst !== 4'd0) begin miscompares++; $display("[TB] FAIL split_drained idle=%b outst=%0d exp=1/0", idle, outst); end
  endtask

  task automatic test_tid_exhaust();
    for (int i = 0; i < 8; i++) begin
      accept(40'h4000 + 40'(i * 8), {$urandom, $urandom}, 8'hFF, 1'b0);
      vectors++; if (l15_val !== 1'b1 || l15_tid !== 3'(i)) begin miscompares++; $display("[TB] FAIL exhaust_tid[%0d] val=%b tid=%0d exp=1/%0d", i, l15_val, l15_tid, i); end
      step(1'b1, 1'b0, 3'd0);
    end
    vectors++; if (outst !== 4'd8) begin miscompares++; $display("[TB] FAIL exhaust_outst got=%0d exp=8", outst); end
    accept(40'h5000, {$urandom, $urandom}, 8'h0F, 1'b0);
    for (int i = 0; i < 2; i++) begin
      vectors++; if (l15_val !== 1'b0) begin miscompares++; $display("[TB] FAIL exhaust_stall[%0d] val got=%b exp=0", i, l15_val); end
      step(1'b0, 1'b0, 3'd0);
    end
    vectors++; if (l15_val !== 1'b0) begin miscompares++; $display("[TB] FAIL exhaust_stall_ackcycle val got=%b exp=0", l15_val); end
    step(1'b0, 1'b1, 3'd5);
    vectors++; if (l15_val !== 1'b1 || l15_tid !== 3'd5 || outst !== 4'd7) begin miscompares++; $display("[TB] FAIL exhaust_reuse val=%b tid=%0d outst=%0d exp=1/5/7", l15_val, l15_tid, outst); end
    vectors++; if (l15_size !== 3'b010 || l15_addr !== 40'h5000) begin miscompares++; $display("[TB] FAIL exhaust_word size=%b addr=%h exp=010/5000", l15_size, l15_addr); end
    step(1'b1, 1'b0, 3'd0);
    vectors++; if (outst !== 4'd8 || st_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL exhaust_full outst=%0d rdy=%b exp=8/1", outst, st_rdy); end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'(i));
    vectors++; if (outst !== 4'd0 || idle !== 1'b1) begin miscompares++; $display("[TB] FAIL exhaust_drain outst=%0d idle=%b exp=0/1", outst, idle); end
  endtask

  task automatic test_same_cycle();
    logic [63:0] d;
    for (int i = 0; i < 3; i++) begin
      accept(40'h6000 + 40'(i * 8), {$urandom, $urandom}, 8'h01, 1'b0);
      step(1'b1, 1'b0, 3'd0);
    end
    vectors++; if (outst !== 4'd3) begin miscompares++; $display("[TB] FAIL same_pre outst=%0d exp=3", outst); end
    accept(40'h6100, {$urandom, $urandom}, 8'h03, 1'b1);
    vectors++; if (l15_tid !== 3'd3 || l15_size !== 3'b001 || l15_nc !== 1'b1) begin miscompares++; $display("[TB] FAIL same_alloc tid=%0d size=%b nc=%b exp=3/001/1", l15_tid, l15_size, l15_nc); end
    step(1'b1, 1'b1, 3'd2);
    vectors++; if (outst !== 4'd3) begin miscompares++; $display("[TB] FAIL same_outst got=%0d exp=3", outst); end
    d = {$urandom, $urandom};
    accept(40'h6200, d, 8'h80, 1'b0);
    vectors++; if (l15_tid !== 3'd2 || l15_addr !== 40'h6207 || l15_size !== 3'b000) begin miscompares++; $display("[TB] FAIL same_refree tid=%0d addr=%h size=%b exp=2/6207/000", l15_tid, l15_addr, l15_size); end
    vectors++; if (l15_data !== {8{d[63:56]}}) begin miscompares++; $display("[TB] FAIL same_byte_rep got=%h exp=%h", l15_data, {8{d[63:56]}}); end
    step(1'b1, 1'b0, 3'd0);
    vectors++; if (err !== 1'b0 || outst !== 4'd4) begin miscompares++; $display("[TB] FAIL same_noerr err=%b outst=%0d exp=0/4", err, outst); end
    step(1'b0, 1'b1, 3'd6);
    vectors++; if (err !== 1'b1 || outst !== 4'd4) begin miscompares++; $display("[TB] FAIL bad_ack err=%b outst=%0d exp=1/4", err, outst); end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'(i));
    vectors++; if (err !== 1'b1 || idle !== 1'b1 || outst !== 4'd0) begin miscompares++; $display("[TB] FAIL err_sticky err=%b idle=%b outst=%0d exp=1/1/0", err, idle, outst); end
  endtask

  task automatic test_reset_midsplit();
    accept(40'h7000, {$urandom, $urandom}, 8'h55, 1'b0);
    step(1'b1, 1'b0, 3'd0);
    step(1'b1, 1'b0, 3'd0);
    vectors++; if (l15_val !== 1'b1 || outst !== 4'd2) begin miscompares++; $display("[TB] FAIL mid_pre val=%b outst=%0d exp=1/2", l15_val, outst); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_bm = '0; m_err = 1'b0; exp_q.delete();
    vectors++; if (l15_val !== 1'b0 || st_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_reset val=%b rdy=%b exp=0/1", l15_val, st_rdy); end
    vectors++; if (idle !== 1'b1 || outst !== 4'd0 || err !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset idle=%b outst=%0d err=%b exp=1/0/0", idle, outst, err); end
  endtask

  task automatic test_random();
    logic [7:0] be;
    logic [2:0] at;
    bit ev, hdr, av;
    int budget;
    for (int s = 0; s < 30; s++) begin
      be = 8'($urandom);
      if (s % 7 == 0) be = 8'h00;
      vectors++; if (st_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL rnd_rdy[%0d] got=%b exp=1", s, st_rdy); end
      accept({$urandom, 8'($urandom)}, {$urandom, $urandom}, be, 1'($urandom));
      budget = 0;
      while (exp_q.size() > 0 && budget < 200) begin
        budget++;
        ev = (lowest_free() >= 0);
        vectors++; if (l15_val !== ev || st_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL rnd_val[%0d] val=%b rdy=%b exp=%b/0", s, l15_val, st_rdy, ev); end
        if (ev) begin
          vectors++;
          if (l15_addr !== exp_q[0].addr || l15_size !== exp_q[0].size || l15_data !== exp_q[0].data ||
              l15_nc !== exp_q[0].nc || l15_tid !== 3'(lowest_free())) begin
            miscompares++;
            $display("[TB] FAIL rnd_chunk[%0d] got=%h/%b/%h/%b/%0d exp=%h/%b/%h/%b/%0d", s, l15_addr, l15_size,
                     l15_data, l15_nc, l15_tid, exp_q[0].addr, exp_q[0].size, exp_q[0].data, exp_q[0].nc, lowest_free());
          end
        end
        vectors++; if (outst !== 4'($countones(m_bm))) begin miscompares++; $display("[TB] FAIL rnd_outst[%0d] got=%0d exp=%0d", s, outst, $countones(m_bm)); end
        hdr = ev && ($urandom_range(3) != 0);
        av = 1'b0; at = 3'd0;
        if (m_bm != 8'h00 && (!ev || $urandom_range(2) == 0)) begin
          av = 1'b1;
          do at = 3'($urandom_range(7)); while (!m_bm[at]);
        end
        step(hdr, av, at);
      end
      if (budget >= 200) begin
        vectors++; miscompares++;
        $display("[TB] FAIL rnd_timeout[%0d] chunks left=%0d exp=0", s, exp_q.size());
        exp_q.delete();
      end
      vectors++; if (l15_val !== 1'b0 || st_rdy !== 1'b1 || idle !== (m_bm == 8'h00)) begin miscompares++; $display("[TB] FAIL rnd_end[%0d] val=%b rdy=%b idle=%b exp=0/1/%b", s, l15_val, st_rdy, idle, m_bm == 8'h00); end
    end
    for (int i = 0; i < 8; i++) if (m_bm[i]) step(1'b0, 1'b1, 3'(i));
    vectors++; if (idle !== 1'b1 || err !== m_err) begin miscompares++; $display("[TB] FAIL rnd_drain idle=%b err=%b exp=1/%b", idle, err, m_err); end
  endtask

  task automatic test_dw32();
    logic [31:0] d;
    d = $urandom;
    st_val32 = 1'b1; st_addr32 = 40'h3000; st_data32 = d; st_be32 = 4'b0000;
    @(posedge clk); #1 st_val32 = 1'b0;
    vectors++; if (st_rdy32 !== 1'b1 || l15_val32 !== 1'b0 || idle32 !== 1'b1) begin miscompares++; $display("[TB] FAIL dw32_zero_be rdy=%b val=%b idle=%b exp=1/0/1", st_rdy32, l15_val32, idle32); end
    step32(1'b0, 1'b0, 3'd0);
    vectors++; if (idle32 !== 1'b1 || l15_val32 !== 1'b0) begin miscompares++; $display("[TB] FAIL dw32_zero_hold idle=%b val=%b exp=1/0", idle32, l15_val32); end
    st_val32 = 1'b1; st_addr32 = 40'h3004; st_data32 = d; st_be32 = 4'b1111;
    @(posedge clk); #1 st_val32 = 1'b0;
    vectors++; if (l15_val32 !== 1'b1 || l15_size32 !== 3'b010 || l15_addr32 !== 40'h3004) begin miscompares++; $display("[TB] FAIL dw32_word val=%b size=%b addr=%h exp=1/010/3004", l15_val32, l15_size32, l15_addr32); end
    vectors++; if (l15_data32 !== d || l15_tid32 !== 3'd0) begin miscompares++; $display("[TB] FAIL dw32_word_data got=%h tid=%0d exp=%h/0", l15_data32, l15_tid32, d); end
    step32(1'b1, 1'b0, 3'd0);
    vectors++; if (st_rdy32 !== 1'b1 || outst32 !== 4'd1) begin miscompares++; $display("[TB] FAIL dw32_after rdy=%b outst=%0d exp=1/1", st_rdy32, outst32); end
    st_val32 = 1'b1; st_addr32 = 40'h3001; st_be32 = 4'b0100;
    @(posedge clk); #1 st_val32 = 1'b0;
    vectors++; if (l15_addr32 !== 40'h3002 || l15_size32 !== 3'b000 || l15_tid32 !== 3'd1) begin miscompares++; $display("[TB] FAIL dw32_byte addr=%h size=%b tid=%0d exp=3002/000/1", l15_addr32, l15_size32, l15_tid32); end
    vectors++; if (l15_data32 !== {4{d[23:16]}}) begin miscompares++; $display("[TB] FAIL dw32_byte_rep got=%h exp=%h", l15_data32, {4{d[23:16]}}); end
    step32(1'b1, 1'b0, 3'd0);
    step32(1'b0, 1'b1, 3'd0);
    step32(1'b0, 1'b1, 3'd1);
    vectors++; if (idle32 !== 1'b1 || outst32 !== 4'd0 || err32 !== 1'b0) begin miscompares++; $display("[TB] FAIL dw32_drain idle=%b outst=%0d err=%b exp=1/0/0", idle32, outst32, err32); end
  endtask

  initial begin
    rst = 1'b1;
    st_val = 1'b0; st_addr = '0; st_data = '0; st_be = '0; st_nc = 1'b0;
    hdr_ack = 1'b0; ack_val = 1'b0; ack_tid = '0;
    st_val32 = 1'b0; st_addr32 = '0; st_data32 = '0; st_be32 = '0;
    hdr_ack32 = 1'b0; ack_val32 = 1'b0; ack_tid32 = '0;
    test_reset();
    test_full_dword();
    test_split();
    test_tid_exhaust();
    test_same_cycle();
    test_reset_midsplit();
    test_random();
    test_dw32();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
